// File: rtl/lives_pkg.sv
// Shared constants for the frog lives counter: FSM encoding, default
// parameter values and the saturation ceiling of the lives count.
package lives_pkg;

  localparam int LIVES_W_DEFAULT        = 3;
  localparam int INIT_LIVES_DEFAULT     = 3;
  localparam int RESPAWN_CYCLES_DEFAULT = 50_000_000;
  localparam int MAX_LIVES_DEFAULT      = (2 ** LIVES_W_DEFAULT) - 1;

  localparam logic [1:0] ST_ALIVE   = 2'd0;
  localparam logic [1:0] ST_RESPAWN = 2'd1;
  localparam logic [1:0] ST_OVER    = 2'd2;

  function automatic int maxLives(input int width);
    return (2 ** width) - 1;
  endfunction

endpackage

// File: rtl/cc_respawn_timer.sv
// Loadable down-counter that times hit immunity; zero flag is decoded from the
// count register so it is valid the cycle after a load.
module cc_respawn_timer #(
  parameter int TIMER_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadValue,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cc_lives_counter.sv
// Frog lives counter: ALIVE/RESPAWN/OVER FSM with registered outputs.
// Define LIVES_COUNTER_BONUS_EN to enable extra-life pulses on the bonus input.
module cc_lives_counter
  import lives_pkg::*;
#(
  parameter int LIVES_COUNTER_DATAWIDTH = LIVES_W_DEFAULT,
  parameter int INIT_LIVES              = INIT_LIVES_DEFAULT,
  parameter int RESPAWN_CYCLES          = RESPAWN_CYCLES_DEFAULT
) (
  input  logic                               CC_LIVES_COUNTER_CLOCK_50,
  input  logic                               CC_LIVES_COUNTER_RESET_InHigh,
  input  logic                               CC_LIVES_COUNTER_start_InHigh,
  input  logic                               CC_LIVES_COUNTER_hit_InHigh,
  input  logic                               CC_LIVES_COUNTER_bonus_InHigh,
  output logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_COUNTER_data_OutBUS,
  output logic                               CC_LIVES_COUNTER_respawn_OutHigh,
  output logic                               CC_LIVES_COUNTER_hitAck_OutHigh,
  output logic                               CC_LIVES_COUNTER_over_OutHigh
);

  localparam int TIMER_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESPAWN_CYCLES - 1);
  localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] MAX_COUNT =
    LIVES_COUNTER_DATAWIDTH'(maxLives(LIVES_COUNTER_DATAWIDTH));
  localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] INIT_COUNT =
    LIVES_COUNTER_DATAWIDTH'(INIT_LIVES);

  if (INIT_LIVES < 1 || INIT_LIVES > maxLives(LIVES_COUNTER_DATAWIDTH)) begin : gBadInitLives
    $error("cc_lives_counter: INIT_LIVES out of range");
  end
  if (RESPAWN_CYCLES < 1) begin : gBadRespawnCycles
    $error("cc_lives_counter: RESPAWN_CYCLES must be at least 1");
  end

  logic                               clk;
  logic                               rst;
  logic                               restart;
  logic                               hit;
  logic                               bonus;
  logic [1:0]                         state;
  logic [LIVES_COUNTER_DATAWIDTH-1:0] count;
  logic                               respawnReg;
  logic                               hitAckReg;
  logic                               overReg;
  logic                               timerLoad;
  logic                               timerDec;
  logic                               timerZero;
  logic                               lastLife;

  assign clk     = CC_LIVES_COUNTER_CLOCK_50;
  assign rst     = CC_LIVES_COUNTER_RESET_InHigh;
  assign restart = rst | CC_LIVES_COUNTER_start_InHigh;
  assign hit     = CC_LIVES_COUNTER_hit_InHigh;
`ifdef LIVES_COUNTER_BONUS_EN
  assign bonus   = CC_LIVES_COUNTER_bonus_InHigh;
`else
  // Port kept for pin compatibility; masked so the count never increments.
  assign bonus   = CC_LIVES_COUNTER_bonus_InHigh & 1'b0;
`endif

  function automatic logic [LIVES_COUNTER_DATAWIDTH-1:0] satInc(
    input logic [LIVES_COUNTER_DATAWIDTH-1:0] value
  );
    return (value == MAX_COUNT) ? value : value + 1'b1;
  endfunction

  // A hit on the last life without a simultaneous bonus ends the game.
  assign lastLife  = (count <= LIVES_COUNTER_DATAWIDTH'(1)) && !bonus;
  assign timerLoad = !restart && (state == ST_ALIVE) && hit && !lastLife;
  assign timerDec  = (state == ST_RESPAWN);

  cc_respawn_timer #(
    .TIMER_W (TIMER_W)
  ) uTimer (
    .clk       (clk),
    .rst       (restart),
    .load      (timerLoad),
    .loadValue (TIMER_LOAD),
    .dec       (timerDec),
    .zero      (timerZero)
  );

  always_ff @(posedge clk) begin
    hitAckReg <= 1'b0;
    if (restart) begin
      state      <= ST_ALIVE;
      count      <= INIT_COUNT;
      respawnReg <= 1'b0;
      overReg    <= 1'b0;
    end else begin
      case (state)
        ST_ALIVE: begin
          if (hit) begin
            hitAckReg <= 1'b1;
            if (lastLife) begin
              count   <= '0;
              state   <= ST_OVER;
              overReg <= 1'b1;
            end else begin
              if (!bonus) count <= count - 1'b1;
              state      <= ST_RESPAWN;
              respawnReg <= 1'b1;
            end
          end else if (bonus) begin
            count <= satInc(count);
          end
        end
        ST_RESPAWN: begin
          if (bonus) count <= satInc(count);
          if (timerZero) begin
            state      <= ST_ALIVE;
            respawnReg <= 1'b0;
          end
        end
        ST_OVER: begin
          count <= '0;
        end
        default: begin
          state      <= ST_ALIVE;
          respawnReg <= 1'b0;
          overReg    <= 1'b0;
        end
      endcase
    end
  end

  assign CC_LIVES_COUNTER_data_OutBUS     = count;
  assign CC_LIVES_COUNTER_respawn_OutHigh = respawnReg;
  assign CC_LIVES_COUNTER_hitAck_OutHigh  = hitAckReg;
  assign CC_LIVES_COUNTER_over_OutHigh    = overReg;

endmodule

// File: tb/tb_cc_lives_counter.sv
// Directed bench for cc_lives_counter (W=3, INIT_LIVES=3, RESPAWN_CYCLES=4);
// bonus expectations follow LIVES_COUNTER_BONUS_EN.
module tb_cc_lives_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       bonus = 1'b0;
  logic [2:0] data;
  logic       respawn;
  logic       hitAck;
  logic       over;

  int compared   = 0;
  int mismatched = 0;

  cc_lives_counter #(
    .LIVES_COUNTER_DATAWIDTH (3),
    .INIT_LIVES              (3),
    .RESPAWN_CYCLES          (4)
  ) dut (
    .CC_LIVES_COUNTER_CLOCK_50        (clk),
    .CC_LIVES_COUNTER_RESET_InHigh    (rst),
    .CC_LIVES_COUNTER_start_InHigh    (start),
    .CC_LIVES_COUNTER_hit_InHigh      (hit),
    .CC_LIVES_COUNTER_bonus_InHigh    (bonus),
    .CC_LIVES_COUNTER_data_OutBUS     (data),
    .CC_LIVES_COUNTER_respawn_OutHigh (respawn),
    .CC_LIVES_COUNTER_hitAck_OutHigh  (hitAck),
    .CC_LIVES_COUNTER_over_OutHigh    (over)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, sample #1 after the edge, then release them.
  task automatic tick(input logic r, input logic s, input logic h, input logic b);
    rst = r; start = s; hit = h; bonus = b;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; hit = 1'b0; bonus = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag, input int d, input int rsp, input int ack, input int ov);
    chk({tag, "_data"}, int'(data), d);
    chk({tag, "_respawn"}, int'(respawn), rsp);
    chk({tag, "_hitAck"}, int'(hitAck), ack);
    chk({tag, "_over"}, int'(over), ov);
  endtask

  initial begin
    @(negedge clk);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chkAll("reset", 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
    chkAll("idle", 3, 0, 0, 0);

    // First hit, immunity window of four cycles, then a second hit
    tick(0, 0, 1, 0);
    chkAll("hit1", 2, 1, 1, 0);
    tick(0, 0, 0, 0);
    chkAll("resp_c2", 2, 1, 0, 0);
    tick(0, 0, 1, 0);
    chkAll("resp_c3", 2, 1, 0, 0);
    tick(0, 0, 1, 0);
    chkAll("resp_c4", 2, 1, 0, 0);
    tick(0, 0, 1, 0);
    chkAll("resp_end", 2, 0, 0, 0);
    tick(0, 0, 1, 0);
    chkAll("hit2", 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chkAll("alive2", 1, 0, 0, 0);

    // Last life lost, OVER holds, start restarts
    tick(0, 0, 1, 0);
    chkAll("hit3_over", 0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chkAll("over_hitbonus", 0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chkAll("over_bonus", 0, 0, 0, 1);
    tick(0, 1, 1, 0);
    chkAll("start", 3, 0, 0, 0);

    // Start beats a same-cycle hit in ALIVE
    tick(0, 1, 1, 1);
    chkAll("start_prio", 3, 0, 0, 0);

`ifdef LIVES_COUNTER_BONUS_EN
    tick(0, 0, 0, 1);
    chk("bonus1", int'(data), 4);
    tick(0, 0, 0, 1);
    chk("bonus2", int'(data), 5);
    tick(0, 0, 0, 1);
    chk("bonus3", int'(data), 6);
    tick(0, 0, 0, 1);
    chk("bonus4", int'(data), 7);
    tick(0, 0, 0, 1);
    chk("bonus_sat", int'(data), 7);
    tick(0, 0, 1, 1);
    chkAll("hitbonus", 7, 1, 1, 0);
`else
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chkAll("bonus_ignored", 3, 0, 0, 0);
    tick(0, 0, 1, 1);
    chkAll("hitbonus", 2, 1, 1, 0);
`endif
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chk("hitbonus_end_respawn", int'(respawn), 0);

    // Reset aborts an active immunity window
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    chkAll("pre_rst_hit", 2, 1, 1, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chkAll("rst_mid_respawn", 3, 0, 0, 0);
    tick(0, 0, 1, 0);
    chkAll("post_rst_hit", 2, 1, 1, 0);

    // Reset overrides same-cycle start/hit/bonus
    tick(1, 1, 1, 1);
    chkAll("rst_override", 3, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cc_lives_counter.md
CC_LIVES_COUNTER -- requirements
Module: cc_lives_counter

Interface
REQ-001 Parameter LIVES_COUNTER_DATAWIDTH, 3, width of lives count (matches downstream lives comparator input).
REQ-002 Parameter INIT_LIVES, 3, lives loaded at reset/new game; legal range 1..2^LIVES_COUNTER_DATAWIDTH-1.
REQ-003 Parameter RESPAWN_CYCLES, 50_000_000, clock cycles of hit immunity after a lost life; legal minimum 1.
REQ-004 CC_LIVES_COUNTER_CLOCK_50  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 CC_LIVES_COUNTER_RESET_InHigh  input  1  reset, synchronous, active-high.
REQ-006 CC_LIVES_COUNTER_start_InHigh  input  1  one-cycle new-game pulse.
REQ-007 CC_LIVES_COUNTER_hit_InHigh  input  1  one-cycle frog collision pulse.
REQ-008 CC_LIVES_COUNTER_bonus_InHigh  input  1  one-cycle extra-life pulse (goal reached).
REQ-009 CC_LIVES_COUNTER_data_OutBUS  output  LIVES_COUNTER_DATAWIDTH  registered lives count, feeds lives comparator.
REQ-010 CC_LIVES_COUNTER_respawn_OutHigh  output  1  high while hit immunity is active.
REQ-011 CC_LIVES_COUNTER_hitAck_OutHigh  output  1  one-cycle pulse per accepted hit.
REQ-012 CC_LIVES_COUNTER_over_OutHigh  output  1  high while in OVER state.

Function
REQ-013 FSM states SHALL be ALIVE, RESPAWN, OVER; all outputs registered.
REQ-014 ALIVE + hit with count>1: count-1, hitAck=1, state RESPAWN, timer loaded RESPAWN_CYCLES-1, all on the next edge.
REQ-015 ALIVE + hit with count=1: count=0, hitAck=1, state OVER on the next edge.
REQ-016 RESPAWN: hits ignored, no hitAck; timer decrements each cycle; timer=0 -> ALIVE next edge; respawn_OutHigh high for exactly RESPAWN_CYCLES cycles.
REQ-017 OVER: count held at 0; hit and bonus ignored; exit only via start or reset.
REQ-018 start pulse in any state: count=INIT_LIVES, state ALIVE, timer=0, respawn/hitAck/over=0 next edge; start has priority over hit and bonus same cycle.
REQ-019 Bonus in ALIVE or RESPAWN: count+1, saturating at 2^LIVES_COUNTER_DATAWIDTH-1, no wrap.
REQ-020 Hit and bonus same cycle in ALIVE: count unchanged, hitAck=1, state RESPAWN (never OVER).
REQ-021 Count SHALL never underflow below 0 or exceed 2^LIVES_COUNTER_DATAWIDTH-1.
REQ-022 Illegal INIT_LIVES or RESPAWN_CYCLES SHALL fail elaboration.

Reset
REQ-023 Reset high at an edge: count=INIT_LIVES, state ALIVE, timer=0, respawn_OutHigh=0, hitAck_OutHigh=0, over_OutHigh=0; reset overrides start, hit and bonus.
REQ-024 Reset during RESPAWN SHALL abort the timer; the first post-reset hit is accepted.

Configuration
REQ-025 Macro LIVES_COUNTER_BONUS_EN defined: REQ-019/REQ-020 bonus behaviour active.
REQ-026 Macro undefined: bonus port remains present but is ignored; count only decrements or reloads; hit+bonus behaves as hit alone.

Structure
REQ-027 Shared package lives_pkg SHALL hold FSM state encoding, default INIT_LIVES, default RESPAWN_CYCLES and the max-lives constant.
REQ-028 Sub-module cc_respawn_timer SHALL implement the loadable down-counter (load, count, zero flag); width derived from RESPAWN_CYCLES.

Verification (W=3, INIT_LIVES=3, RESPAWN_CYCLES=4)
REQ-029 Reset then idle 10 cycles -> data=3, respawn=0, over=0, hitAck=0.
REQ-030 Hit at cycle 0 -> cycle 1 data=2, hitAck=1 one cycle, respawn=1 cycles 1-4, hits at cycles 2-4 ignored, hit at cycle 5 -> data=1.
REQ-031 Three spaced hits -> data=0, over=1; further hits/bonus keep data=0; start -> next cycle data=3, over=0.
REQ-032 With LIVES_COUNTER_BONUS_EN: 5 bonuses from 3 -> data saturates at 7; hit+bonus same cycle at data=7 -> data=7, respawn=1.
REQ-033 Without LIVES_COUNTER_BONUS_EN: bonus pulses -> data stays 3; hit+bonus -> data=2.
REQ-034 Reset asserted mid-RESPAWN with data=2 -> next cycle data=3, respawn=0; hit next cycle -> data=2, hitAck=1.
